// File: rtl/mirfak_multdiv_unit_pkg.sv
// Shared types and helpers for the M-extension multiply/divide unit.
// Provides the funct3 opcode enum, FSM state enum, divider result payload
// and a conditional two's-complement helper used for sign/magnitude fixes.
package mirfak_multdiv_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  typedef struct packed {
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
  } div_result_t;

  // Two's-complement negate when neg is set.
  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] x, input logic neg);
    return neg ? (~x + XLEN'(1)) : x;
  endfunction

  // Absolute value of x when interpreted as signed, x itself otherwise.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic is_signed);
    return negate_if(x, is_signed && x[XLEN-1]);
  endfunction

endpackage

// File: rtl/mirfak_divider.sv
// Iterative restoring radix-2 divider core, one quotient bit per step.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   start_i         load operands (magnitudes) and sign flags, counter=31
//   step_i          perform one iteration this cycle
//   is_signed_i     operands are signed (DIV/REM)
//   dividend_i      operand A
//   divisor_i       operand B (never zero; special cases handled by the caller)
//   done_o          combinational: the current step is the last one (counter==0)
//   result_o        combinational sign-fixed quotient/remainder, valid with done_o
module mirfak_divider
  import mirfak_multdiv_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            is_signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output div_result_t     result_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    trial;
  logic             qbit;
  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  quo_nxt;

  // One restoring step; quo_q shifts dividend bits out and quotient bits in.
  always_comb begin
    rem_shift          = {rem_q, quo_q[XLEN-1]};
    trial              = rem_shift - {1'b0, dvs_q};
    qbit               = ~trial[XLEN];
    rem_nxt            = qbit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_nxt            = {quo_q[XLEN-2:0], qbit};
    done_o             = step_i && (cnt_q == '0);
    result_o.quotient  = negate_if(quo_nxt, neg_quo_q);
    result_o.remainder = negate_if(rem_nxt, neg_rem_q);
  end

  // Iteration state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start_i) begin
      cnt_q     <= CNT_W'(XLEN - 1);
      rem_q     <= '0;
      quo_q     <= magnitude(dividend_i, is_signed_i);
      dvs_q     <= magnitude(divisor_i, is_signed_i);
      neg_quo_q <= is_signed_i && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
      neg_rem_q <= is_signed_i && dividend_i[XLEN-1];
    end else if (step_i) begin
      cnt_q     <= cnt_q - CNT_W'(1);
      rem_q     <= rem_nxt;
      quo_q     <= quo_nxt;
    end
  end

endmodule

// File: rtl/mirfak_multdiv_unit.sv
// EX-stage M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Stalls the pipeline via ex_busy_o while computing and holds the result
// in DONE until the EX->WB register advances.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   ex_md_valid_i   EX holds a valid M-extension instruction
//   ex_md_op_i      funct3 opcode
//   ex_rs1_i/rs2_i  forwarded operands
//   exwb_enable_i   EX->WB register advances this cycle
//   ex_kill_i       exception/xret flush
//   ex_busy_o       combinational stall request
//   ex_result_o     registered result, valid in DONE
module mirfak_multdiv_unit
  import mirfak_multdiv_unit_pkg::*;
#(
  parameter bit FAST_MUL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_md_valid_i,
  input  logic [2:0]      ex_md_op_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_rs2_i,
  input  logic            exwb_enable_i,
  input  logic            ex_kill_i,
  output logic            ex_busy_o,
  output logic [XLEN-1:0] ex_result_o
);

  md_state_e         state_q, state_d;
  md_op_e            op_q;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              a_signed, b_signed, div_signed;
  logic              div_by_zero, div_overflow;

  logic              mul_start, mul_step, mul_done;
  logic [2*XLEN-1:0] mul_product;
  logic [XLEN-1:0]   mul_result;

  logic              div_start, div_step, div_done;
  div_result_t       div_result;

  // Operand signedness and divider special cases, decoded from the EX inputs.
  always_comb begin
    a_signed     = (ex_md_op_i[1:0] != 2'b11);
    b_signed     = ~ex_md_op_i[1];
    div_signed   = ~ex_md_op_i[0];
    div_by_zero  = (ex_rs2_i == '0);
    div_overflow = div_signed && (ex_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (ex_rs2_i == '1);
  end

  if (FAST_MUL) begin : g_fast_mul
    logic [XLEN:0] a_q, b_q;

    // 33b sign/zero-extended operands captured on accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        a_q <= '0;
        b_q <= '0;
      end else if (mul_start) begin
        a_q <= {a_signed & ex_rs1_i[XLEN-1], ex_rs1_i};
        b_q <= {b_signed & ex_rs2_i[XLEN-1], ex_rs2_i};
      end
    end

    assign mul_done    = mul_step;
    assign mul_product = {{(XLEN-1){a_q[XLEN]}}, a_q} * {{(XLEN-1){b_q[XLEN]}}, b_q};
  end else begin : g_iter_mul
    logic [2*XLEN-1:0] acc_q, mcand_q, acc_nxt;
    logic [XLEN-1:0]   mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;

    // Shift-add on magnitudes; the sign is applied to the final sum.
    always_comb begin
      acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        acc_q    <= '0;
        mcand_q  <= '0;
        mplier_q <= '0;
        cnt_q    <= '0;
        neg_q    <= 1'b0;
      end else if (mul_start) begin
        acc_q    <= '0;
        mcand_q  <= {{XLEN{1'b0}}, magnitude(ex_rs1_i, a_signed)};
        mplier_q <= magnitude(ex_rs2_i, b_signed);
        cnt_q    <= CNT_W'(XLEN - 1);
        neg_q    <= (a_signed & ex_rs1_i[XLEN-1]) ^ (b_signed & ex_rs2_i[XLEN-1]);
      end else if (mul_step) begin
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end

    assign mul_done    = mul_step && (cnt_q == '0);
    assign mul_product = neg_q ? (~acc_nxt + (2*XLEN)'(1)) : acc_nxt;
  end

  assign mul_result = (op_q == MD_MUL) ? mul_product[XLEN-1:0] : mul_product[2*XLEN-1:XLEN];

  mirfak_divider u_divider (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (div_start),
    .step_i      (div_step),
    .is_signed_i (div_signed),
    .dividend_i  (ex_rs1_i),
    .divisor_i   (ex_rs2_i),
    .done_o      (div_done),
    .result_o    (div_result)
  );

  // Next-state, stall and datapath control.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    accept    = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;
    ex_busy_o = ex_md_valid_i && (state_q != ST_DONE) && !ex_kill_i;

    if (ex_kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_md_valid_i) begin
            accept = 1'b1;
            if (!ex_md_op_i[2]) begin
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end else if (div_by_zero) begin
              state_d  = ST_DONE;
              result_d = ex_md_op_i[1] ? ex_rs1_i : '1;
            end else if (div_overflow) begin
              state_d  = ST_DONE;
              result_d = ex_md_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (!ex_md_valid_i) begin
            state_d = ST_IDLE;
          end else begin
            mul_step = 1'b1;
            if (mul_done) begin
              state_d  = ST_DONE;
              result_d = mul_result;
            end
          end
        end
        ST_DIV: begin
          if (!ex_md_valid_i) begin
            state_d = ST_IDLE;
          end else begin
            div_step = 1'b1;
            if (div_done) begin
              state_d  = ST_DONE;
              result_d = op_q[1] ? div_result.remainder : div_result.quotient;
            end
          end
        end
        ST_DONE: begin
          if (exwb_enable_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, opcode and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q <= md_op_e'(ex_md_op_i);
      end
    end
  end

  assign ex_result_o = result_q;

endmodule

// File: tb/tb_mirfak_multdiv_unit.sv
// Self-checking bench for mirfak_multdiv_unit (FAST_MUL=1).
module tb_mirfak_multdiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_md_valid_i;
  logic [2:0]  ex_md_op_i;
  logic [31:0] ex_rs1_i;
  logic [31:0] ex_rs2_i;
  logic        exwb_enable_i;
  logic        ex_kill_i;
  logic        ex_busy_o;
  logic [31:0] ex_result_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        exp_on   = 1'b0;
  logic [31:0] exp_result = '0;

  always #5 clk_i = ~clk_i;

  mirfak_multdiv_unit #(.FAST_MUL(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ex_md_valid_i (ex_md_valid_i),
    .ex_md_op_i    (ex_md_op_i),
    .ex_rs1_i      (ex_rs1_i),
    .ex_rs2_i      (ex_rs2_i),
    .exwb_enable_i (exwb_enable_i),
    .ex_kill_i     (ex_kill_i),
    .ex_busy_o     (ex_busy_o),
    .ex_result_o   (ex_result_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lit;
    bit          has_lit;
    int          hold;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Architectural result of an M-extension op, from RISC-V semantics.
  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0]     r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin up = ua * ub; r = up[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
    endcase
    return r;
  endfunction

  // Expected number of busy cycles seen from the first cycle valid is presented.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // While the bench expects DONE: not busy, result equals the model.
  always @(negedge clk_i) begin
    #2;
    if (exp_on) begin
      check("done_busy", {31'd0, ex_busy_o}, 32'd0);
      check("done_result", ex_result_o, exp_result);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_md_op_i    = op;
    ex_rs1_i      = a;
    ex_rs2_i      = b;
    ex_md_valid_i = 1'b1;
  endtask

  task automatic wait_done(input int lat, input string name);
    int cnt = 0;
    #1;
    while (ex_busy_o && cnt < 200) begin
      cnt++;
      @(negedge clk_i);
      #1;
    end
    check({name, "_latency"}, 32'(cnt), 32'(lat));
  endtask

  task automatic observe(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input bit has_lit, input int hold,
                         input string name);
    wait_done(exp_lat(op, a, b), name);
    exp_result = md_model(op, a, b);
    exp_on     = 1'b1;
    if (has_lit) check({name, "_literal"}, ex_result_o, lit);
    repeat (hold) @(negedge clk_i);
  endtask

  task automatic retire();
    @(negedge clk_i);
    exp_on        = 1'b0;
    exwb_enable_i = 1'b1;
    ex_md_valid_i = 1'b0;
    @(negedge clk_i);
    exwb_enable_i = 1'b0;
  endtask

  task automatic do_op(input vec_t v, input string name);
    @(negedge clk_i);
    issue(v.op, v.a, v.b);
    observe(v.op, v.a, v.b, v.lit, v.has_lit, v.hold, name);
    retire();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 0};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1};
    vecs[2]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 1'b1, 0};
    vecs[3]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 1'b1, 0};
    vecs[4]  = '{3'd5, 32'd100,        32'd7,          32'd14,        1'b1, 5};
    vecs[5]  = '{3'd4, 32'd1234,       32'd0,          32'hFFFF_FFFF, 1'b1, 0};
    vecs[6]  = '{3'd6, 32'd5,          32'd0,          32'd5,         1'b1, 2};
    vecs[7]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0};
    vecs[8]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 0};
    vecs[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 0};
    vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 1'b1, 0};
    vecs[11] = '{3'd7, 32'd100,        32'd7,          32'd2,         1'b1, 0};
    vecs[12] = '{3'd5, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, 1'b1, 0};
    vecs[13] = '{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1'b1, 0};
    vecs[14] = '{3'd4, 32'h8000_0000, 32'd1,          32'h8000_0000, 1'b1, 0};
    vecs[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 0};

    rst_ni        = 1'b0;
    ex_md_valid_i = 1'b0;
    ex_md_op_i    = '0;
    ex_rs1_i      = '0;
    ex_rs2_i      = '0;
    exwb_enable_i = 1'b0;
    ex_kill_i     = 1'b0;
    #12;
    check("reset_busy", {31'd0, ex_busy_o}, 32'd0);
    check("reset_result", ex_result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: DIVU enters EX in the same cycle MULH retires.
    @(negedge clk_i);
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    observe(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 0, "b2b_mulh");
    @(negedge clk_i);
    exp_on        = 1'b0;
    exwb_enable_i = 1'b1;
    issue(3'd5, 32'hDEAD_BEEF, 32'd1000);
    #1;
    check("b2b_done_busy", {31'd0, ex_busy_o}, 32'd0);
    @(negedge clk_i);
    exwb_enable_i = 1'b0;
    observe(3'd5, 32'hDEAD_BEEF, 32'd1000, 32'd3_735_928, 1'b1, 1, "b2b_divu");
    retire();

    // Kill mid-divide, then the same op restarts from scratch.
    @(negedge clk_i);
    issue(3'd4, 32'hFFFF_FF9C, 32'd7);
    repeat (10) @(negedge clk_i);
    ex_kill_i = 1'b1;
    #1;
    check("kill_busy", {31'd0, ex_busy_o}, 32'd0);
    @(negedge clk_i);
    ex_kill_i = 1'b0;
    issue(3'd4, 32'hFFFF_FF9C, 32'd7);
    observe(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b1, 0, "post_kill");
    retire();

    // Valid dropping mid-divide abandons it; a fresh op runs full length.
    @(negedge clk_i);
    issue(3'd5, 32'd1000, 32'd3);
    repeat (5) @(negedge clk_i);
    ex_md_valid_i = 1'b0;
    do_op('{3'd7, 32'd1000, 32'd3, 32'd1, 1'b1, 0}, "post_bubble");

    // Reset mid-operation clears the held result.
    @(negedge clk_i);
    issue(3'd4, 32'd1000, 32'd3);
    repeat (5) @(negedge clk_i);
    rst_ni        = 1'b0;
    ex_md_valid_i = 1'b0;
    #1;
    check("midreset_result", ex_result_o, 32'd0);
    check("midreset_busy", {31'd0, ex_busy_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_op('{3'd0, 32'd12345, 32'd6789, 32'd83_810_205, 1'b1, 0}, "post_reset");

    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
